bcd_score_counter: RTL and testbench

- Clocked, parametrised multi-digit BCD score counter for the VGA game score display. It is the successor to the two-digit up/down score counter.
- Adds a configurable digit count, a variable BCD step, saturate or wrap mode, a synchronous clear, a high-score register and status flags.
- Feeds the per-digit score drawing logic. The game-logic FSM drives it with single-cycle event strobes.

---
 rtl/bcd_score_counter.sv | 123 ++++++++++++
 tb/tb_bcd_score_counter.sv | 139 +++++++++++++
 2 files changed

// File: rtl/bcd_score_counter.sv
// Multi-digit BCD score counter with saturate/wrap, synchronous clear,
// high-score tracking and at_max / at_zero decodes.

// One BCD digit of the add/subtract ripple chain.
module bcd_digit_addsub (
    input  logic       i_sub,
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_d,
    output logic       o_cout
);
    logic [4:0] w_raw;
    logic [4:0] w_adj;

    always_comb begin
        w_raw  = 5'd0;
        w_adj  = 5'd0;
        o_d    = 4'd0;
        o_cout = 1'b0;
        if (i_sub) begin
            // Operands are 0..9, so the difference lies in -10..9 and bit 4 is the sign.
            w_raw = {1'b0, i_a} - {1'b0, i_b} - {4'd0, i_cin};
            w_adj = w_raw + 5'd10;
            if (w_raw[4]) begin
                o_d    = w_adj[3:0];
                o_cout = 1'b1;
            end else begin
                o_d    = w_raw[3:0];
            end
        end else begin
            w_raw = {1'b0, i_a} + {1'b0, i_b} + {4'd0, i_cin};
            w_adj = w_raw - 5'd10;
            if (w_raw > 5'd9) begin
                o_d    = w_adj[3:0];
                o_cout = 1'b1;
            end else begin
                o_d    = w_raw[3:0];
            end
        end
    end
endmodule

module bcd_score_counter #(
    parameter int NUM_DIGITS = 4,
    parameter int SATURATE   = 1
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic                    up,
    input  logic                    down,
    input  logic [3:0]              step,
    input  logic                    clear,
    output logic [4*NUM_DIGITS-1:0] score,
    output logic [4*NUM_DIGITS-1:0] high_score,
    output logic                    new_high,
    output logic                    at_max,
    output logic                    at_zero
);
    localparam int W = 4 * NUM_DIGITS;
    localparam logic [W-1:0] ALL9 = {NUM_DIGITS{4'h9}};

    logic [W-1:0]          r_score;
    logic [W-1:0]          r_high;
    logic                  r_new_high;

    logic [3:0]            w_step;
    logic [NUM_DIGITS:0]   w_carry;
    logic [W-1:0]          w_result;
    logic [W-1:0]          w_next;

    assign w_step     = (step > 4'd9) ? 4'd9 : step;
    assign w_carry[0] = 1'b0;

    // Step enters at the units digit; higher digits only see the ripple.
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
        logic [3:0] w_b;
        assign w_b = (g == 0) ? w_step : 4'd0;
        bcd_digit_addsub u_dig (
            .i_sub  (down),
            .i_a    (r_score[4*g +: 4]),
            .i_b    (w_b),
            .i_cin  (w_carry[g]),
            .o_d    (w_result[4*g +: 4]),
            .o_cout (w_carry[g+1])
        );
    end

    always_comb begin
        w_next = r_score;
        if (clear) begin
            w_next = '0;
        end else if (up ^ down) begin
            if (w_carry[NUM_DIGITS] && (SATURATE != 0))
                w_next = up ? ALL9 : '0;
            else
                w_next = w_result;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_score    <= '0;
            r_high     <= '0;
            r_new_high <= 1'b0;
        end else begin
            r_score <= w_next;
            // Packed BCD orders the same as binary, so a plain compare suffices.
            if (w_next > r_high) begin
                r_high     <= w_next;
                r_new_high <= 1'b1;
            end else begin
                r_new_high <= 1'b0;
            end
        end
    end

    assign score      = r_score;
    assign high_score = r_high;
    assign new_high   = r_new_high;
    assign at_max     = (r_score == ALL9);
    assign at_zero    = (r_score == '0);
endmodule

// File: tb/tb_bcd_score_counter.sv
// Directed bench: one shared stimulus drives a saturating 2-digit, a wrapping
// 2-digit and a wrapping 4-digit counter, each checked against hand values.
module tb_bcd_score_counter;
    logic        clk = 1'b0;
    logic        resetN;
    logic        up, down, clear;
    logic [3:0]  step;
    logic [7:0]  s_score, s_high, w_score, w_high;
    logic [15:0] d_score, d_high;
    logic        s_nh, s_max, s_zero, w_nh, w_max, w_zero, d_nh, d_max, d_zero;
    int          n_pass = 0;
    int          n_tot  = 0;

    always #5 clk = ~clk;

    bcd_score_counter #(.NUM_DIGITS(2), .SATURATE(1)) u_s (
        .clk(clk), .resetN(resetN), .up(up), .down(down), .step(step), .clear(clear),
        .score(s_score), .high_score(s_high), .new_high(s_nh), .at_max(s_max), .at_zero(s_zero));
    bcd_score_counter #(.NUM_DIGITS(2), .SATURATE(0)) u_w (
        .clk(clk), .resetN(resetN), .up(up), .down(down), .step(step), .clear(clear),
        .score(w_score), .high_score(w_high), .new_high(w_nh), .at_max(w_max), .at_zero(w_zero));
    bcd_score_counter #(.NUM_DIGITS(4), .SATURATE(0)) u_d (
        .clk(clk), .resetN(resetN), .up(up), .down(down), .step(step), .clear(clear),
        .score(d_score), .high_score(d_high), .new_high(d_nh), .at_max(d_max), .at_zero(d_zero));

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetN = 1'b1; up = 1'b0; down = 1'b0; clear = 1'b0; step = 4'd0;
        #1 resetN = 1'b0;
        #2;
        chk("rst_score",    s_score, 16'h0);
        chk("rst_high",     s_high,  16'h0);
        chk("rst_new_high", s_nh,    16'h0);
        chk("rst_at_zero",  s_zero,  16'h1);
        chk("rst_at_max",   s_max,   16'h0);
        chk("rst_d_score",  d_score, 16'h0);
        @(negedge clk) resetN = 1'b1;

        // 12 single steps up
        up = 1'b1; step = 4'd1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            chk("count_new_high", s_nh, 16'h1);
            if (i == 1) chk("count_at_zero_low", s_zero, 16'h0);
        end
        chk("count12_score", s_score, 16'h12);
        chk("count12_high",  s_high,  16'h12);
        chk("count12_d",     d_score, 16'h0012);

        // climb to 95: nine steps of 9, then 2
        step = 4'd9;
        for (int i = 0; i < 9; i++) tick();
        chk("climb_93", s_score, 16'h93);
        step = 4'd2; tick();
        chk("climb_95", w_score, 16'h95);

        // 95 + 7: saturate, wrap, and carry into the third digit
        step = 4'd7; tick();
        chk("sat_score",     s_score, 16'h99);
        chk("sat_at_max",    s_max,   16'h1);
        chk("sat_new_high",  s_nh,    16'h1);
        chk("wrap_score",    w_score, 16'h02);
        chk("wrap_high",     w_high,  16'h95);
        chk("wrap_new_high", w_nh,    16'h0);
        chk("d_carry",       d_score, 16'h0102);
        step = 4'd1; tick();
        chk("sat_hold",      s_score, 16'h99);
        chk("sat_hold_nh",   s_nh,    16'h0);
        chk("wrap_03",       w_score, 16'h03);

        // clear beats up; highs untouched
        clear = 1'b1; step = 4'd9; tick();
        clear = 1'b0;
        chk("clr_score",    s_score, 16'h00);
        chk("clr_high",     s_high,  16'h99);
        chk("clr_nh",       d_nh,    16'h0);
        chk("clr_d_high",   d_high,  16'h0103);
        step = 4'd3; tick();
        chk("to_03", s_score, 16'h03);

        // 03 - 5: clamp, wrap to 98, 4-digit borrow chain to 9998
        up = 1'b0; down = 1'b1; step = 4'd5; tick();
        chk("sub_sat",      s_score, 16'h00);
        chk("sub_at_zero",  s_zero,  16'h1);
        chk("sub_wrap",     w_score, 16'h98);
        chk("sub_wrap_high",w_high,  16'h98);
        chk("sub_wrap_nh",  w_nh,    16'h1);
        chk("sub_d",        d_score, 16'h9998);
        chk("sub_d_high",   d_high,  16'h9998);

        // 9998 + 5 wraps to 0003, high held
        down = 1'b0; up = 1'b1; step = 4'd5; tick();
        chk("d_wrap",       d_score, 16'h0003);
        chk("d_wrap_high",  d_high,  16'h9998);
        chk("d_wrap_nh",    d_nh,    16'h0);
        chk("sat_05",       s_score, 16'h05);
        chk("wrap_103",     w_score, 16'h03);

        // up and down together: hold
        down = 1'b1; step = 4'd4; tick();
        chk("both_s",  s_score, 16'h05);
        chk("both_w",  w_score, 16'h03);
        chk("both_nh", s_nh,    16'h0);

        // step 0 holds; step C clamps to 9
        down = 1'b0; step = 4'd0; tick();
        chk("step0", s_score, 16'h05);
        step = 4'hC; tick();
        chk("stepC_s", s_score, 16'h14);
        chk("stepC_w", w_score, 16'h12);
        chk("stepC_d", d_score, 16'h0012);

        // async reset mid-cycle while up is held
        step = 4'd1;
        #2 resetN = 1'b0;
        #1;
        chk("arst_score", s_score, 16'h00);
        chk("arst_high",  s_high,  16'h00);
        chk("arst_zero",  s_zero,  16'h1);
        #2 resetN = 1'b1;
        tick();
        chk("post_rst_score", s_score, 16'h01);
        chk("post_rst_high",  s_high,  16'h01);
        chk("post_rst_nh",    s_nh,    16'h1);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
